// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the ID/EX pipeline register
package pipe_pkg;

  localparam int unsigned PIPE_XLEN     = 32;
  localparam int unsigned PIPE_CTRL_W   = 8;
  localparam int unsigned PIPE_ALUC_W   = 4;
  localparam int unsigned PIPE_REGIDX_W = 5;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Control bundle layout {WB[2:0], Mem[1:0], Exe[2:0]}
  localparam int unsigned CTRL_WB_HI  = 7;
  localparam int unsigned CTRL_WB_LO  = 5;
  localparam int unsigned CTRL_MEM_HI = 4;
  localparam int unsigned CTRL_MEM_LO = 3;
  localparam int unsigned CTRL_EXE_HI = 2;
  localparam int unsigned CTRL_EXE_LO = 0;

  typedef struct packed {
    logic [31:0]              instr;
    logic [PIPE_CTRL_W-1:0]   ctrl;
    logic [PIPE_XLEN-1:0]     data1;
    logic [PIPE_XLEN-1:0]     data2;
    logic [PIPE_XLEN-1:0]     immgen;
    logic [PIPE_ALUC_W-1:0]   aluc;
    logic [PIPE_REGIDX_W-1:0] wbreg;
    logic [PIPE_XLEN-1:0]     pc_add4;
  } id_ex_payload_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - payload register with load enable and valid bit
module pipe_skid_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic         kill_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;

  // Kill wins over load; a killed slot keeps its stale payload.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (kill_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/exe_stage_pipe_reg.sv
// rtl/exe_stage_pipe_reg.sv - ID/EX register with 2-entry skid buffer and flush
// Optional perf counters: EXE_STAGE_PERF_EN
module exe_stage_pipe_reg #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned CTRL_W    = 8,
  parameter int unsigned ALUC_W    = 4,
  parameter int unsigned REGIDX_W  = 5,
  parameter logic [31:0] NOP_INSTR = pipe_pkg::NOP_INSTR
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [31:0]         instr_i,
  input  logic [CTRL_W-1:0]   ctrl_i,
  input  logic [XLEN-1:0]     data1_i,
  input  logic [XLEN-1:0]     data2_i,
  input  logic [XLEN-1:0]     immgen_i,
  input  logic [ALUC_W-1:0]   aluc_i,
  input  logic [REGIDX_W-1:0] wbreg_i,
  input  logic [XLEN-1:0]     pc_add4_i,
  output logic                valid_o,
  input  logic                ready_i,
  output logic [31:0]         instr_o,
  output logic [CTRL_W-1:0]   ctrl_o,
  output logic [XLEN-1:0]     data1_o,
  output logic [XLEN-1:0]     data2_o,
  output logic [XLEN-1:0]     immgen_o,
  output logic [ALUC_W-1:0]   aluc_o,
  output logic [REGIDX_W-1:0] wbreg_o,
  output logic [XLEN-1:0]     pc_add4_o
`ifdef EXE_STAGE_PERF_EN
  ,
  output logic [31:0]         stall_cnt_o,
  output logic [31:0]         flush_cnt_o
`endif
);

  import pipe_pkg::*;

  localparam int unsigned P_PC    = 0;
  localparam int unsigned P_WB    = P_PC + XLEN;
  localparam int unsigned P_ALUC  = P_WB + REGIDX_W;
  localparam int unsigned P_IMM   = P_ALUC + ALUC_W;
  localparam int unsigned P_D2    = P_IMM + XLEN;
  localparam int unsigned P_D1    = P_D2 + XLEN;
  localparam int unsigned P_CTRL  = P_D1 + XLEN;
  localparam int unsigned P_INSTR = P_CTRL + CTRL_W;
  localparam int unsigned PW      = P_INSTR + 32;

  // Reset asserts asynchronously, releases on a clock edge.
  logic rst_meta_q, rst_q;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rst_meta_q <= 1'b1;
      rst_q      <= 1'b1;
    end else begin
      rst_meta_q <= 1'b0;
      rst_q      <= rst_meta_q;
    end
  end

  pipe_state_e state_q, state_d;
  logic        ready_q;
  logic        accept, drain;
  logic        main_load, main_kill, skid_load, skid_kill;
  logic        main_valid, skid_valid;
  logic [PW-1:0] in_payload, main_data, skid_data, main_src;

  assign in_payload = {instr_i, ctrl_i, data1_i, data2_i, immgen_i, aluc_i, wbreg_i, pc_add4_i};

  assign accept = valid_i && ready_q;
  assign drain  = main_valid && ready_i;

  always_comb begin
    state_d   = state_q;
    main_load = 1'b0;
    main_kill = 1'b0;
    skid_load = 1'b0;
    skid_kill = 1'b0;
    if (flush_i) begin
      state_d   = EMPTY;
      main_kill = 1'b1;
      skid_kill = 1'b1;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            main_load = 1'b1;
            state_d   = FULL;
          end
        end
        FULL: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (drain) begin
            main_kill = 1'b1;
            state_d   = EMPTY;
          end else if (accept) begin
            skid_load = 1'b1;
            state_d   = SKID;
          end
        end
        SKID: begin
          if (drain) begin
            main_load = 1'b1;
            skid_kill = 1'b1;
            state_d   = FULL;
          end
        end
        default: begin
          main_kill = 1'b1;
          skid_kill = 1'b1;
          state_d   = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_q) begin
    if (rst_q) begin
      state_q <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d != SKID);
    end
  end

  // Skid only holds data in SKID, which is the only state where main refills from it.
  assign main_src = skid_valid ? skid_data : in_payload;

  pipe_skid_slot #(.W(PW)) u_main_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_q),
    .load_i  (main_load),
    .kill_i  (main_kill),
    .data_i  (main_src),
    .valid_o (main_valid),
    .data_o  (main_data)
  );

  pipe_skid_slot #(.W(PW)) u_skid_slot (
    .clk_i   (clk_i),
    .rst_i   (rst_q),
    .load_i  (skid_load),
    .kill_i  (skid_kill),
    .data_i  (in_payload),
    .valid_o (skid_valid),
    .data_o  (skid_data)
  );

  assign ready_o   = ready_q;
  assign valid_o   = main_valid;
  // Bubbles present a NOP with a zero control bundle so EXE never writes state.
  assign instr_o   = main_valid ? main_data[P_INSTR +: 32] : NOP_INSTR;
  assign ctrl_o    = main_valid ? main_data[P_CTRL +: CTRL_W] : '0;
  assign data1_o   = main_data[P_D1 +: XLEN];
  assign data2_o   = main_data[P_D2 +: XLEN];
  assign immgen_o  = main_data[P_IMM +: XLEN];
  assign aluc_o    = main_data[P_ALUC +: ALUC_W];
  assign wbreg_o   = main_data[P_WB +: REGIDX_W];
  assign pc_add4_o = main_data[P_PC +: XLEN];

`ifdef EXE_STAGE_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (main_valid && !ready_i) stall_cnt_d = stall_cnt_q + 32'd1;
    if (flush_i && (main_valid || skid_valid || accept)) flush_cnt_d = flush_cnt_q + 32'd1;
  end

  always_ff @(posedge clk_i or posedge rst_q) begin
    if (rst_q) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_exe_stage_pipe_reg.sv
// tb/tb_exe_stage_pipe_reg.sv - scoreboard bench for exe_stage_pipe_reg
module tb_exe_stage_pipe_reg;
  import pipe_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic        ready_o, valid_o;
  logic [31:0] instr_i, instr_o;
  logic [7:0]  ctrl_i, ctrl_o;
  logic [31:0] data1_i, data2_i, immgen_i, pc_add4_i;
  logic [31:0] data1_o, data2_o, immgen_o, pc_add4_o;
  logic [3:0]  aluc_i, aluc_o;
  logic [4:0]  wbreg_i, wbreg_o;
`ifdef EXE_STAGE_PERF_EN
  logic [31:0] stall_cnt_o, flush_cnt_o;
`endif

  id_ex_payload_t obs;
  assign obs = {instr_o, ctrl_o, data1_o, data2_o, immgen_o, aluc_o, wbreg_o, pc_add4_o};

  id_ex_payload_t sb[$];
  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  exe_stage_pipe_reg dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .instr_i(instr_i), .ctrl_i(ctrl_i), .data1_i(data1_i), .data2_i(data2_i),
    .immgen_i(immgen_i), .aluc_i(aluc_i), .wbreg_i(wbreg_i), .pc_add4_i(pc_add4_i),
    .valid_o(valid_o), .ready_i(ready_i),
    .instr_o(instr_o), .ctrl_o(ctrl_o), .data1_o(data1_o), .data2_o(data2_o),
    .immgen_o(immgen_o), .aluc_o(aluc_o), .wbreg_o(wbreg_o), .pc_add4_o(pc_add4_o)
`ifdef EXE_STAGE_PERF_EN
    , .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
`endif
  );

  function automatic id_ex_payload_t mk(input logic [31:0] instr, input logic [7:0] ctrl);
    id_ex_payload_t p;
    p.instr   = instr;
    p.ctrl    = ctrl;
    p.data1   = $urandom;
    p.data2   = $urandom;
    p.immgen  = $urandom;
    p.aluc    = 4'($urandom);
    p.wbreg   = 5'($urandom);
    p.pc_add4 = $urandom;
    return p;
  endfunction

  // Called at a negedge: compare outputs with the scoreboard, drive inputs, advance one cycle.
  task automatic step(input logic v, input id_ex_payload_t p, input logic rdy, input logic fl);
    logic acc, drn;
    valid_i = v; ready_i = rdy; flush_i = fl;
    {instr_i, ctrl_i, data1_i, data2_i, immgen_i, aluc_i, wbreg_i, pc_add4_i} = p;
    checks++;
    if (valid_o !== (sb.size() > 0)) begin
      errors++; $display("FAIL valid_o: got %b want %b", valid_o, sb.size() > 0);
    end
    checks++;
    if (ready_o !== (sb.size() < 2)) begin
      errors++; $display("FAIL ready_o: got %b want %b", ready_o, sb.size() < 2);
    end
    checks++;
    if (sb.size() > 0) begin
      if (obs !== sb[0]) begin
        errors++; $display("FAIL payload: got %h want %h", obs, sb[0]);
      end
    end else if (instr_o !== NOP_INSTR || ctrl_o !== 8'h00) begin
      errors++; $display("FAIL bubble: got instr %h ctrl %h want %h 00", instr_o, ctrl_o, NOP_INSTR);
    end
    acc = v && (sb.size() < 2);
    drn = (sb.size() > 0) && rdy;
    if (fl) sb.delete();
    else begin
      if (drn) void'(sb.pop_front());
      if (acc) sb.push_back(p);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, mk($urandom, 8'($urandom)), rdy, 1'b0);
  endtask

  task automatic apply_reset();
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    sb.delete();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    idle(3, 1'b0);
  endtask

  task automatic test_reset();
    rst_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
    {instr_i, ctrl_i, data1_i, data2_i, immgen_i, aluc_i, wbreg_i, pc_add4_i} = '0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL reset_hs: got valid %b ready %b want 0 1", valid_o, ready_o);
    end
    checks++;
    if (obs !== {NOP_INSTR, 145'd0}) begin
      errors++; $display("FAIL reset_payload: got %h want %h", obs, {NOP_INSTR, 145'd0});
    end
    rst_i = 1'b0;
    sb.delete();
    idle(3, 1'b0);
  endtask

  task automatic test_streaming();
    logic [31:0] ins [4];
    int vcnt;
    ins[0] = 32'h0050_0093; ins[1] = 32'h00A0_0113; ins[2] = 32'h0020_81B3; ins[3] = 32'h4020_8233;
    vcnt = 0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, mk(ins[i], 8'h80 | 8'(i)), 1'b1, 1'b0);
      checks++;
      if (instr_o !== ins[i] || ready_o !== 1'b1) begin
        errors++; $display("FAIL stream_%0d: got %h rdy %b want %h rdy 1", i, instr_o, ready_o, ins[i]);
      end
      if (valid_o) vcnt++;
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, mk(32'h0, 8'h0), 1'b1, 1'b0);
      if (valid_o) vcnt++;
    end
    checks++;
    if (vcnt != 4) begin
      errors++; $display("FAIL stream_valid_cycles: got %0d want 4", vcnt);
    end
  endtask

  task automatic test_backpressure();
    id_ex_payload_t a, b;
    a = mk(32'h1111_1111, 8'h21);
    b = mk(32'h2222_2222, 8'h42);
    step(1'b1, a, 1'b1, 1'b0);
    step(1'b1, b, 1'b0, 1'b0);
    checks++;
    if (ready_o !== 1'b0 || obs !== a) begin
      errors++; $display("FAIL bp_hold: got rdy %b instr %h want rdy 0 instr %h", ready_o, instr_o, a.instr);
    end
    step(1'b0, mk(32'h0, 8'h0), 1'b1, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || obs !== b) begin
      errors++; $display("FAIL bp_release: got v %b instr %h want v 1 instr %h", valid_o, instr_o, b.instr);
    end
    idle(2, 1'b1);
  endtask

  task automatic test_flush();
    step(1'b1, mk(32'hA000_0001, 8'h11), 1'b0, 1'b0);
    step(1'b1, mk(32'hB000_0002, 8'h22), 1'b0, 1'b0);
    step(1'b1, mk(32'hC000_0003, 8'h33), 1'b0, 1'b1);
    checks++;
    if (valid_o !== 1'b0 || ctrl_o !== 8'h00 || instr_o !== 32'h0000_0013 || ready_o !== 1'b1) begin
      errors++; $display("FAIL flush: got v %b ctrl %h instr %h rdy %b want 0 00 00000013 1",
                         valid_o, ctrl_o, instr_o, ready_o);
    end
    idle(3, 1'b1);
  endtask

  task automatic test_async_reset();
    id_ex_payload_t p;
    p = mk(32'h0000_0033, 8'h5A);
    p.data1 = 32'hDEAD_BEEF;
    step(1'b1, p, 1'b0, 1'b0);
    checks++;
    if (data1_o !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL async_pre: got %h want deadbeef", data1_o);
    end
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if (obs !== {NOP_INSTR, 145'd0} || valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++; $display("FAIL async_reset: got %h v %b rdy %b want %h v 0 rdy 1",
                         obs, valid_o, ready_o, {NOP_INSTR, 145'd0});
    end
    sb.delete();
    valid_i = 1'b0;
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    idle(3, 1'b0);
  endtask

  task automatic test_drain_bubble();
    step(1'b1, mk(32'h0010_0093, 8'hA5), 1'b1, 1'b0);
    checks++;
    if (ctrl_o !== 8'hA5 || valid_o !== 1'b1) begin
      errors++; $display("FAIL drain_first: got ctrl %h v %b want a5 1", ctrl_o, valid_o);
    end
    step(1'b0, mk(32'h0, 8'h0), 1'b1, 1'b0);
    checks++;
    if (ctrl_o !== 8'h00 || valid_o !== 1'b0 || instr_o !== NOP_INSTR) begin
      errors++; $display("FAIL drain_bubble: got ctrl %h v %b instr %h want 00 0 %h",
                         ctrl_o, valid_o, instr_o, NOP_INSTR);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++)
      step(($urandom % 4) != 0, mk($urandom, 8'($urandom)), ($urandom % 3) != 0, ($urandom % 23) == 0);
    idle(3, 1'b1);
  endtask

`ifdef EXE_STAGE_PERF_EN
  task automatic test_perf();
    apply_reset();
    step(1'b1, mk(32'h0000_0013, 8'h01), 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) step(1'b0, mk(32'h0, 8'h0), 1'b0, 1'b0);
    step(1'b0, mk(32'h0, 8'h0), 1'b1, 1'b1);
    checks++;
    if (stall_cnt_o !== 32'd7 || flush_cnt_o !== 32'd1) begin
      errors++; $display("FAIL perf: got stall %0d flush %0d want 7 1", stall_cnt_o, flush_cnt_o);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_drain_bubble();
    test_random();
`ifdef EXE_STAGE_PERF_EN
    test_perf();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
